// File: rtl/reset_sequencer_pkg.sv
// rst_seq_pkg: shared FSM encoding and width helpers for the reset sequencer and its users.
// Pure declarations, no logic; no latency or backpressure.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_RELEASE = 3'd1,
    ST_DONE    = 3'd2,
    ST_ASSERT  = 3'd3,
    ST_HOLD    = 3'd4
  } rst_state_t;

  function automatic int cnt_width(input int step_cycles, input int hold_cycles);
    int m;
    m = (step_cycles > hold_cycles) ? step_cycles : hold_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  function automatic int idx_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: software request, release holds and sequenced reset outputs of one clock domain.
// Level signals only, no handshake and no backpressure.
interface reset_sequencer_if #(
  parameter int NUM_CH = 4
);
  logic              sw_rst_req;
  logic [NUM_CH-1:0] ch_hold;
  logic [NUM_CH-1:0] srst_n;
  logic              rst_done;
  logic              busy;

  modport master (input sw_rst_req, ch_hold, output srst_n, rst_done, busy);
  modport slave  (output sw_rst_req, ch_hold, input srst_n, rst_done, busy);
endinterface

// File: rtl/reset_sync_chain.sv
// reset_sync_chain: async-assert / sync-deassert reset synchroniser, STAGES flops deep.
// Release latency STAGES clk edges, assertion immediate; no backpressure.
module reset_sync_chain #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic arst_n,
  output logic o_sync_rst_n
);
  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], 1'b1};
    end
  end

  assign o_sync_rst_n = r_sync[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_CH resets in order, STEP_CYCLES apart, ch k at edge SYNC_STAGES+1+(k+1)*STEP_CYCLES; no backpressure.
// RSTSEQ_STAGED_ASSERT_EN: software re-reset asserts channels in reverse order STEP_CYCLES apart.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int NUM_CH         = 4,
  parameter int STEP_CYCLES    = 16,
  parameter int SW_HOLD_CYCLES = 8
) (
  input logic               clk,
  input logic               arst_n,
  reset_sequencer_if.master bus
);
  localparam int CW = cnt_width(STEP_CYCLES, SW_HOLD_CYCLES);
  localparam int IW = idx_width(NUM_CH);
  localparam logic [CW-1:0] STEP_TC  = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_TC  = CW'(SW_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  rst_state_t        r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic [NUM_CH-1:0] r_srst_n, w_srst_n_nxt;
  logic              r_rst_done, w_rst_done_nxt;
  logic              r_busy;
  logic              w_sync_rst_n;
  logic              w_step_tc, w_hold_tc, w_accept;

  reset_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk          (clk),
    .arst_n       (arst_n),
    .o_sync_rst_n (w_sync_rst_n)
  );

  assign w_step_tc = (r_cnt == STEP_TC);
  assign w_hold_tc = (r_cnt == HOLD_TC);
  assign w_accept  = bus.sw_rst_req && ((r_state == ST_RELEASE) || (r_state == ST_DONE));

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_srst_n_nxt   = r_srst_n;
    w_rst_done_nxt = 1'b0;
    case (r_state)
      ST_RESET: begin
        if (w_sync_rst_n) begin
          w_state_nxt = ST_RELEASE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      ST_RELEASE: begin
        if (!w_step_tc) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end else if (!bus.ch_hold[r_idx]) begin
          w_srst_n_nxt[r_idx] = 1'b1;
          w_cnt_nxt           = '0;
          w_idx_nxt           = r_idx + IDX_ONE;
          if (r_idx == IDX_LAST) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_rst_done_nxt = 1'b1;
      ST_ASSERT: begin
        // idx points at the most recently asserted channel; channel 0 ends the walk
        if (r_idx == '0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end else if (!w_step_tc) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
          w_idx_nxt                    = r_idx - IDX_ONE;
          w_srst_n_nxt[r_idx - IDX_ONE] = 1'b0;
          w_cnt_nxt                    = '0;
        end
      end
      ST_HOLD: begin
        if (w_hold_tc) begin
          w_state_nxt = ST_RELEASE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: w_state_nxt = ST_RESET;
    endcase

    // A request overrides any release due on the same edge
    if (w_accept) begin
      w_state_nxt    = ST_ASSERT;
      w_cnt_nxt      = '0;
      w_rst_done_nxt = 1'b0;
`ifdef RSTSEQ_STAGED_ASSERT_EN
      w_idx_nxt                  = IDX_LAST;
      w_srst_n_nxt               = r_srst_n;
      w_srst_n_nxt[NUM_CH-1]     = 1'b0;
`else
      w_idx_nxt                  = '0;
      w_srst_n_nxt               = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= ST_RESET;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_srst_n   <= '0;
      r_rst_done <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_srst_n   <= w_srst_n_nxt;
      r_rst_done <= w_rst_done_nxt;
      r_busy     <= (w_state_nxt != ST_DONE);
    end
  end

  assign bus.srst_n   = r_srst_n;
  assign bus.rst_done = r_rst_done;
  assign bus.busy     = r_busy;
endmodule
